fp_mul_pipe: RTL
================

// Module: fp_mul_pipe
// PURPOSE
//  Parametrised 3-stage pipelined IEEE-754-style FP multiplier: unpack, normalise, round, pack.
//  Generic exponent/mantissa widths, valid/ready flow control, two rounding modes, exception flags.
//  Drop-in datapath element for the HW3 FP arithmetic blocks.
//  Default config is binary16.
// PARAMETERS
//  EXP_W  5   exponent field width (bias = 2**(EXP_W-1)-1)
//  MAN_W  10  stored mantissa width (hidden bit excluded); N = 1+EXP_W+MAN_W (localparam)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operand pair a/b valid
//  in_ready   out  1      block accepts operands this cycle
//  a          in   N      operand a {sign, exp, man}
//  b          in   N      operand b
//  rnd_mode   in   1      0 = round-nearest-even, 1 = round-toward-zero; sampled with a/b
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  result     out  N      a*b
//  flags      out  4      {invalid, overflow, underflow, inexact}, aligned with result
// BEHAVIOUR
//  Reset: all stage valids 0; out_valid=0, result=0, flags=0 on the cycle after rst=1.
//   Reset mid-flight drops all in-flight ops; nothing is emitted for them.
//  Flow: adv = !s3_valid | out_ready; in_ready = adv; all stages shift when adv=1, hold when 0.
//   Transfer in: in_valid&in_ready. Transfer out: out_valid&out_ready.
//   Bubbles propagate (no collapse). Latency 3 cycles; throughput 1/cycle when out_ready=1.
//   result/flags stay stable while out_valid=1 && out_ready=0.
//  S1: unpack; classify zero/sub/inf/nan/snan.
//   Subnormal inputs are flushed to zero, with no flag.
//   Sign = sa^sb. Exponent e = ea+eb-bias, signed, width EXP_W+2.
//   Product = {1,ma}*{1,mb}, width 2*(MAN_W+1).
//  S2: if product MSB=1, shift right by 1 and increment e.
//   Extract MAN_W mantissa bits, guard, round, and sticky (OR of the remaining bits).
//  S3: rounding.
//   RNE: increment when g & (r|s|lsb).
//   RTZ: truncate.
//   Mantissa carry-out -> mantissa=0, e+1.
//  S3 exceptions, in priority order:
//   1. Any NaN input -> canonical qNaN {0, all-1 exp, 1, 0...}.
//      invalid=1 if either input is a signalling NaN (mantissa MSB 0, mantissa nonzero).
//   2. Inf*0 -> canonical qNaN, invalid=1.
//   3. Inf*finite -> signed inf, no flags.
//   4. Zero operand -> signed zero, no flags.
//   5. e >= 2**EXP_W-1 after rounding -> overflow=1, inexact=1.
//      RNE gives signed inf; RTZ gives signed max-finite.
//   6. e <= 0 -> flush to signed zero; underflow=1, inexact=1.
//   7. Otherwise normal result; inexact = g|r|s.
//  No denormal outputs. Zero sign is always sa^sb.
// STRUCTURE
//  Package fp_pkg:
//   - fp_class_e enum (ZERO, NORM, INF, QNAN, SNAN)
//   - flag bit index constants
//   - RNE/RTZ constants
//   - canonical-NaN function of (EXP_W, MAN_W)
//  Sub-module fp_round: combinational round/pack used by S3.
//   Inputs: sign, e, mantissa, g, r, s, rnd_mode.
//   Outputs: packed word and flags.
//  Stage registers live inline in fp_mul_pipe.
// TESTING (binary16 defaults, out_ready=1 unless stated)
//  1. 0x3C00*0x4000 -> 0x4000, flags 0, exactly 3 cycles later.
//     0x3E00*0x3E00 -> 0x4080, flags 0.
//  2. Tie: 0x3C01*0x3E00.
//     RNE -> 0x3E02, inexact.
//     RTZ -> 0x3E01, inexact.
//  3. Overflow: 0x7BFF*0x7BFF.
//     RNE -> 0x7C00, flags 0b0101.
//     RTZ -> 0x7BFF, flags 0b0101.
//  4. Specials:
//     0x7C00*0x0000 -> 0x7E00, invalid.
//     0xFC00*0x4000 -> 0xFC00, flags 0.
//     0x7D00*0x3C00 -> 0x7E00, invalid.
//     0x0001*0x3C00 -> 0x0000, flags 0.
//  5. Underflow: 0x0400*0x3800 -> 0x0000, flags 0b0011.
//     0x8400*0x3800 -> 0x8000.
//  6. Backpressure/reset:
//     - 5 back-to-back ops with out_ready=0: exactly 3 accepted, then in_ready=0, result held.
//     - Release out_ready: results emerge in order, none lost or duplicated.
//     - Assert rst with 2 ops in flight: out_valid=0 on the next cycle; no stale output after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the pipelined FP multiplier.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package fp_pkg;

  // Operand classes after unpack; subnormals are folded into CLS_ZERO.
  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp_class_e;

  // Bit positions inside flags = {invalid, overflow, underflow, inexact}.
  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  // rnd_mode encodings.
  localparam logic RND_RNE = 1'b0;
  localparam logic RND_RTZ = 1'b1;

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set.
  // Returned wide; callers truncate to their word width.
  function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_round.sv
// Rounds a normalised mantissa and packs it, handling overflow and underflow.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the enclosing pipeline stage owns flow control.
// Ports: sign/e/man/g/r/s describe the unrounded value, rnd_mode selects
//        RNE or RTZ; word is the packed result, flags {inv, ovf, unf, inx}.
module fp_round import fp_pkg::*; #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                     sign,
  input  logic signed [EXP_W+1:0]  e,
  input  logic [MAN_W-1:0]         man,
  input  logic                     g,
  input  logic                     r,
  input  logic                     s,
  input  logic                     rnd_mode,
  output logic [EXP_W+MAN_W:0]     word,
  output logic [3:0]               flags
);

  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ZERO = '0;

  logic              inc;
  logic [MAN_W:0]    man_sum;
  logic signed [EW-1:0] e_r;

  // Round-to-nearest-even increments above half, or at exactly half when lsb is odd.
  assign inc     = (rnd_mode == RND_RNE) && g && (r || s || man[0]);
  assign man_sum = {1'b0, man} + {{MAN_W{1'b0}}, inc};
  // On carry-out the low bits are already zero, so only the exponent moves.
  assign e_r     = e + $signed({{(EW-1){1'b0}}, man_sum[MAN_W]});

  always_comb begin
    flags = '0;
    word  = {sign, e_r[EXP_W-1:0], man_sum[MAN_W-1:0]};
    if (e_r >= E_MAX) begin
      flags[FLG_OVERFLOW] = 1'b1;
      flags[FLG_INEXACT]  = 1'b1;
      if (rnd_mode == RND_RTZ)
        word = {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      else
        word = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (e_r <= E_ZERO) begin
      // No denormal outputs: anything below the normal range becomes signed zero.
      flags[FLG_UNDERFLOW] = 1'b1;
      flags[FLG_INEXACT]   = 1'b1;
      word = {sign, {(EXP_W+MAN_W){1'b0}}};
    end else begin
      flags[FLG_INEXACT] = g | r | s;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage pipelined floating-point multiplier (unpack/multiply, normalise, round/pack).
// Latency: 3 cycles from input transfer to out_valid; throughput 1 op/cycle.
// Backpressure: whole pipe stalls when the output register is full and out_ready=0.
// Ports: clk/rst (sync, active-high); in_valid/in_ready with a, b, rnd_mode;
//        out_valid/out_ready with result and flags {invalid, overflow, underflow, inexact}.
module fp_mul_pipe import fp_pkg::*; #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+MAN_W:0]  a,
  input  logic [EXP_W+MAN_W:0]  b,
  input  logic                  rnd_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+MAN_W:0]  result,
  output logic [3:0]            flags
);

  localparam int N  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * (MAN_W + 1);
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [N-1:0]         QNAN = N'(canon_nan(EXP_W, MAN_W));

  function automatic fp_class_e classify(input logic [EXP_W-1:0] ex, input logic [MAN_W-1:0] mn);
    if (ex == '0)
      return CLS_ZERO;  // subnormals flushed silently
    if (ex == '1) begin
      if (mn == '0)
        return CLS_INF;
      return mn[MAN_W-1] ? CLS_QNAN : CLS_SNAN;
    end
    return CLS_NORM;
  endfunction

  // out_valid doubles as the stage-3 valid; every stage advances together.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- Stage 1: unpack, exponent sum, significand product
  fp_class_e            ca_c, cb_c;
  logic signed [EW-1:0] e1_c;
  logic [PW-1:0]        prod_c;

  always_comb begin
    ca_c   = classify(a[N-2:MAN_W], a[MAN_W-1:0]);
    cb_c   = classify(b[N-2:MAN_W], b[MAN_W-1:0]);
    e1_c   = $signed({2'b00, a[N-2:MAN_W]}) + $signed({2'b00, b[N-2:MAN_W]}) - BIAS;
    prod_c = PW'({1'b1, a[MAN_W-1:0]}) * PW'({1'b1, b[MAN_W-1:0]});
  end

  logic                 s1_valid, s1_sign, s1_rnd;
  logic signed [EW-1:0] s1_e;
  logic [PW-1:0]        s1_prod;
  fp_class_e            s1_ca, s1_cb;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_sign  <= a[N-1] ^ b[N-1];
      s1_rnd   <= rnd_mode;
      s1_e     <= e1_c;
      s1_prod  <= prod_c;
      s1_ca    <= ca_c;
      s1_cb    <= cb_c;
    end
  end

  // ---------------- Stage 2: normalise and extract mantissa/g/r/s
  // Product of two [1,2) significands lies in [1,4); the top bit says which half.
  logic                 hi;
  logic signed [EW-1:0] e2_c;
  logic [MAN_W-1:0]     man2_c;
  logic                 g2_c, r2_c, st2_c;

  assign hi   = s1_prod[PW-1];
  assign e2_c = s1_e + $signed({{(EW-1){1'b0}}, hi});

  always_comb begin
    if (hi) begin
      man2_c = s1_prod[PW-2:MAN_W+1];
      g2_c   = s1_prod[MAN_W];
      r2_c   = s1_prod[MAN_W-1];
      st2_c  = |s1_prod[MAN_W-2:0];
    end else begin
      man2_c = s1_prod[PW-3:MAN_W];
      g2_c   = s1_prod[MAN_W-1];
      r2_c   = s1_prod[MAN_W-2];
      st2_c  = |s1_prod[MAN_W-3:0];
    end
  end

  logic                 s2_valid, s2_sign, s2_rnd;
  logic signed [EW-1:0] s2_e;
  logic [MAN_W-1:0]     s2_man;
  logic                 s2_g, s2_r, s2_s;
  fp_class_e            s2_ca, s2_cb;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_rnd   <= s1_rnd;
      s2_e     <= e2_c;
      s2_man   <= man2_c;
      s2_g     <= g2_c;
      s2_r     <= r2_c;
      s2_s     <= st2_c;
      s2_ca    <= s1_ca;
      s2_cb    <= s1_cb;
    end
  end

  // ---------------- Stage 3: round, special-case override, output register
  logic [N-1:0] rnd_word;
  logic [3:0]   rnd_flags;

  fp_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .sign     (s2_sign),
    .e        (s2_e),
    .man      (s2_man),
    .g        (s2_g),
    .r        (s2_r),
    .s        (s2_s),
    .rnd_mode (s2_rnd),
    .word     (rnd_word),
    .flags    (rnd_flags)
  );

  logic         nan_any, snan_any, inf_any, zero_any;
  logic [N-1:0] res_c;
  logic [3:0]   flg_c;

  always_comb begin
    snan_any = (s2_ca == CLS_SNAN) || (s2_cb == CLS_SNAN);
    nan_any  = snan_any || (s2_ca == CLS_QNAN) || (s2_cb == CLS_QNAN);
    inf_any  = (s2_ca == CLS_INF) || (s2_cb == CLS_INF);
    zero_any = (s2_ca == CLS_ZERO) || (s2_cb == CLS_ZERO);
    res_c    = rnd_word;
    flg_c    = rnd_flags;
    if (nan_any) begin
      res_c = QNAN;
      flg_c = '0;
      flg_c[FLG_INVALID] = snan_any;
    end else if (inf_any && zero_any) begin
      res_c = QNAN;
      flg_c = '0;
      flg_c[FLG_INVALID] = 1'b1;
    end else if (inf_any) begin
      res_c = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_c = '0;
    end else if (zero_any) begin
      res_c = {s2_sign, {(N-1){1'b0}}};
      flg_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      result    <= res_c;
      flags     <= flg_c;
    end
  end

endmodule
